// File: rtl/compressed_fetch_aligner.sv
// compressed_fetch_aligner: fetches aligned 32-bit words into a small halfword
// queue and presents one whole instruction (16-bit RVC or 32-bit, including
// word-straddling 32-bit ones) at a time to the decode stage.
//
// Handshakes: a transfer on the decode side happens on a rising edge where
// InstrValid && InstrReady; the memory side accepts a request on an edge where
// MemReq && MemGnt and returns exactly one MemRValid per accepted request.
module compressed_fetch_aligner #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QUEUE_HW = 4
) (
   input  logic        Clock,
   input  logic        ResetN,
   output logic        MemReq,
   output logic [31:0] MemAddr,
   input  logic        MemGnt,
   input  logic        MemRValid,
   input  logic [31:0] MemRData,
   input  logic        RedirectValid,
   input  logic [31:0] RedirectPc,
   output logic        InstrValid,
   input  logic        InstrReady,
   output logic [31:0] Instr,
   output logic [31:0] InstrPc,
   output logic        InstrIsRvc,
   output logic [1:0]  DebugState
);

   localparam int              CntW           = $clog2(QUEUE_HW + 1);
   localparam logic [CntW-1:0] ReqLimit       = CntW'(QUEUE_HW - 2);
   localparam logic [31:0]     ResetPcAligned = RESET_PC & ~32'd1;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StWait = 2'd2,
      StKill = 2'd3
   } fetchState_t;

   fetchState_t            state, stateNext;
   logic [CntW-1:0]        count, countNext, keepCnt, popCnt, pushCnt;
   logic [QUEUE_HW*16-1:0] qData, qDataNext;
   logic [QUEUE_HW*32-1:0] qPc, qPcNext;
   logic [31:0]            fetchPc, memAddrQ, wordBase, pushPc0;
   logic [15:0]            pushData0;
   logic                   issue, pushEn, headRvc;

   assign MemReq     = (state == StReq);
   assign MemAddr    = memAddrQ;
   assign DebugState = state;

   // Decode the queue head into the presented instruction (zero latency)
   always_comb begin
      headRvc    = (qData[1:0] != 2'b11);
      InstrValid = 1'b0;
      Instr      = '0;
      InstrIsRvc = 1'b0;
      InstrPc    = (count == '0) ? fetchPc : qPc[31:0];
      if (count != '0 && headRvc) begin
         InstrValid = 1'b1;
         Instr      = {16'h0000, qData[15:0]};
         InstrIsRvc = 1'b1;
      end else if (count >= CntW'(2) && !headRvc) begin
         InstrValid = 1'b1;
         Instr      = {qData[31:16], qData[15:0]};
      end
   end

   // Fetch FSM: next state, request issue and response push decisions
   always_comb begin
      stateNext = state;
      issue     = 1'b0;
      pushEn    = 1'b0;
      case (state)
         StIdle: begin
            // Never issue on a redirect cycle: the fetch pointer is about to change.
            if (!RedirectValid && count <= ReqLimit) begin
               stateNext = StReq;
               issue     = 1'b1;
            end
         end
         StReq: begin
            if (RedirectValid) stateNext = MemGnt ? StKill : StIdle;
            else if (MemGnt)   stateNext = StWait;
         end
         StWait: begin
            if (MemRValid) begin
               stateNext = StIdle;
               pushEn    = !RedirectValid;
            end else if (RedirectValid) begin
               stateNext = StKill;
            end
         end
         StKill: begin
            // The owed response is dropped; a redirect alone keeps us waiting for it.
            if (MemRValid) stateNext = StIdle;
         end
         default: stateNext = StIdle;
      endcase
   end

   // Queue update: pop the consumed parcels, then append the returned halfwords
   always_comb begin
      popCnt = '0;
      if (InstrValid && InstrReady) popCnt = InstrIsRvc ? CntW'(1) : CntW'(2);
      keepCnt   = count - popCnt;
      pushCnt   = !pushEn ? '0 : (fetchPc[1] ? CntW'(1) : CntW'(2));
      wordBase  = {fetchPc[31:2], 2'b00};
      pushData0 = fetchPc[1] ? MemRData[31:16] : MemRData[15:0];
      pushPc0   = fetchPc[1] ? (wordBase | 32'd2) : wordBase;
      qDataNext = qData >> {popCnt, 4'b0000};
      qPcNext   = qPc >> {popCnt, 5'b00000};
      for (int i = 0; i < QUEUE_HW; i++) begin
         if (pushCnt != '0 && CntW'(i) == keepCnt) begin
            qDataNext[i*16 +: 16] = pushData0;
            qPcNext[i*32 +: 32]   = pushPc0;
         end
         if (pushCnt == CntW'(2) && CntW'(i) == keepCnt + CntW'(1)) begin
            qDataNext[i*16 +: 16] = MemRData[31:16];
            qPcNext[i*32 +: 32]   = wordBase | 32'd2;
         end
      end
      countNext = keepCnt + pushCnt;
   end

   // State, queue, fetch pointer and request address registers
   always_ff @(posedge Clock) begin
      if (!ResetN) begin
         state    <= StIdle;
         count    <= '0;
         qData    <= '0;
         qPc      <= '0;
         fetchPc  <= ResetPcAligned;
         memAddrQ <= '0;
      end else begin
         state <= stateNext;
         qData <= qDataNext;
         qPc   <= qPcNext;
         if (issue) memAddrQ <= {fetchPc[31:2], 2'b00};
         if (RedirectValid) begin
            count   <= '0;
            fetchPc <= RedirectPc & ~32'd1;
         end else begin
            count <= countNext;
            if (pushEn) fetchPc <= wordBase + 32'd4;
         end
      end
   end

endmodule
